// File: rtl/alu_pkg.sv
// Shared op codes, flag bit positions and op classification helpers for the
// ALU execute stage.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_OR  = 4'd0,
      OP_XOR = 4'd1,
      OP_AND = 4'd2,
      OP_ROR = 4'd3,
      OP_SHR = 4'd4,
      OP_SHL = 4'd5,
      OP_ADD = 4'd8,
      OP_SUB = 4'd9,
      OP_ASR = 4'd10
   } alu_op_t;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic is_legal_op(input logic [3:0] op);
      logic legal;
      case (op)
         OP_OR, OP_XOR, OP_AND, OP_ROR, OP_SHR, OP_SHL,
         OP_ADD, OP_SUB, OP_ASR: legal = 1'b1;
         default:                legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Arithmetic ops are the only ones allowed to overwrite C and V in the status register
   function automatic logic is_arith_op(input logic [3:0] op);
      logic arith;
      case (op)
         OP_ADD, OP_SUB, OP_ASR: arith = 1'b1;
         default:                arith = 1'b0;
      endcase
      return arith;
   endfunction

endpackage

// File: rtl/arithmetic_logic_unit.sv
// Combinational ALU: logic ops, shifts/rotate by operand b, add/sub with
// carry and signed overflow. WIDTH is expected to be a power of two.
module arithmetic_logic_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             negative,
   output logic             zero,
   output logic             carry_out,
   output logic             overflow
);

   localparam int SW = $clog2(WIDTH);

   logic [WIDTH:0]          add_wide;
   logic [WIDTH:0]          sub_wide;
   logic [2*WIDTH-1:0]      ror_wide;
   logic signed [WIDTH:0]   asr_wide;
   logic [SW-1:0]           rot_amt;

   assign rot_amt  = b[SW-1:0];
   assign add_wide = {1'b0, a} + {1'b0, b};
   // Subtract as a + ~b + 1 so the carry reads as "no borrow" (a >= b unsigned)
   assign sub_wide = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
   assign ror_wide = {a, a} >> rot_amt;
   // An extra guard bit below the LSB captures the last bit shifted out
   assign asr_wide = $signed({a, 1'b0}) >>> b;

   always_comb begin
      result    = '0;
      carry_out = 1'b0;
      overflow  = 1'b0;
      case (op)
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_AND: result = a & b;
         OP_ROR: result = ror_wide[WIDTH-1:0];
         OP_SHR: result = a >> b;
         OP_SHL: result = a << b;
         OP_ADD: begin
            result    = add_wide[WIDTH-1:0];
            carry_out = add_wide[WIDTH];
            overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (add_wide[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result    = sub_wide[WIDTH-1:0];
            carry_out = sub_wide[WIDTH];
            overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_wide[WIDTH-1] != a[WIDTH-1]);
         end
         OP_ASR: begin
            result    = asr_wide[WIDTH:1];
            carry_out = asr_wide[0];
         end
         default: result = '0;
      endcase
   end

   assign negative = result[WIDTH-1];
   assign zero     = (result == '0);

endmodule

// File: rtl/nzcv_status_reg.sv
// Architectural NZCV register; N/Z always follow the retiring result, C/V only
// change for arithmetic ops.
module nzcv_status_reg
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       update,
   input  logic       arith,
   input  logic       n,
   input  logic       z,
   input  logic       c,
   input  logic       v,
   output logic [3:0] nzcv
);

   always_ff @(posedge clk) begin
      if (rst) begin
         nzcv <= '0;
      end else if (update) begin
         nzcv[FLAG_N] <= n;
         nzcv[FLAG_Z] <= z;
         if (arith) begin
            nzcv[FLAG_C] <= c;
            nzcv[FLAG_V] <= v;
         end
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// Two-stage execute pipeline around arithmetic_logic_unit: S1 holds the issued
// operands, S2 holds the captured result/flags presented on the out_* handshake.
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_set_flags,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             out_illegal,
   output logic [3:0]       status_nzcv
);

   logic             s1_valid;
   logic [3:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic             s1_set_flags;
   logic             s2_valid;

   logic             adv2;
   logic             s1_move;
   logic             in_fire;
   logic             s1_legal;

   logic [WIDTH-1:0] alu_result;
   logic             alu_n;
   logic             alu_z;
   logic             alu_c;
   logic             alu_v;

   // S2 can take a new op when empty or when its current op leaves this cycle
   assign adv2      = !s2_valid || out_ready;
   assign s1_move   = s1_valid && adv2;
   assign in_ready  = !s1_valid || adv2;
   assign in_fire   = in_valid && in_ready;
   assign s1_legal  = is_legal_op(s1_op);
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
      end else begin
         if (in_fire) begin
            s1_valid     <= 1'b1;
            s1_op        <= in_op;
            s1_a         <= in_a;
            s1_b         <= in_b;
            s1_set_flags <= in_set_flags;
         end else if (s1_move) begin
            s1_valid <= 1'b0;
         end
      end
   end

   arithmetic_logic_unit #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a         (s1_a),
      .b         (s1_b),
      .op        (s1_op),
      .result    (alu_result),
      .negative  (alu_n),
      .zero      (alu_z),
      .carry_out (alu_c),
      .overflow  (alu_v)
   );

   // Illegal ops retire with a zeroed result and flags so consumers never see ALU junk
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid    <= 1'b0;
         out_result  <= '0;
         out_flags   <= '0;
         out_illegal <= 1'b0;
      end else if (s1_move) begin
         s2_valid    <= 1'b1;
         out_illegal <= !s1_legal;
         if (s1_legal) begin
            out_result <= alu_result;
            out_flags  <= {alu_n, alu_z, alu_c, alu_v};
         end else begin
            out_result <= '0;
            out_flags  <= '0;
         end
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   nzcv_status_reg u_status (
      .clk    (clk),
      .rst    (rst),
      .update (s1_move && s1_legal && s1_set_flags),
      .arith  (is_arith_op(s1_op)),
      .n      (alu_n),
      .z      (alu_z),
      .c      (alu_c),
      .v      (alu_v),
      .nzcv   (status_nzcv)
   );

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
Pipelined execute stage wrapped around arithmetic_logic_unit, which it instantiates. Accepts operation requests from the decode/issue side over a valid/ready handshake and registers the operands into the ALU. Captures the result and flags in an output register with its own valid/ready handshake. Maintains the architectural NZCV status register that downstream branch/condition logic reads.

Parameters:
WIDTH, 8, operand and result width in bits, passed to arithmetic_logic_unit.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  stage can accept a request this cycle
in_op  input  4  ALU select code
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B (shift/rotate amount for shift ops)
in_set_flags  input  1  update NZCV when this op retires
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  registered ALU result
out_flags  output  4  registered {N,Z,C,V} of this op
out_illegal  output  1  op code was not a legal select
status_nzcv  output  4  architectural status register {N,Z,C,V}

Behaviour:
- Legal op codes: 0 OR, 1 XOR, 2 AND, 3 rotate right, 4 logical shift right, 5 shift left, 8 ADD, 9 SUB, 10 arithmetic shift right. Codes 6, 7 and 11-15 are illegal.
- Two register stages. S1 holds op, a, b, set_flags and valid; it feeds the ALU. S2 holds result, flags, illegal and valid; it drives the out_* ports.
- Transfers: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- adv2 = !s2_valid || out_ready. S1 moves into S2 when s1_valid && adv2.
- in_ready = !s1_valid || adv2. It is combinational and does not depend on in_valid.
- Latency: a request accepted at edge k gives out_valid high after edge k+1, so the result is visible in the cycle after the next one. Throughput is 1 op/cycle while out_ready is high.
- Stall: while out_valid && !out_ready, S2 holds all values stable. S1 also holds if it is occupied. The stage fills at 2 ops, then in_ready = 0. No drop, no duplication, order preserved.
- Simultaneous events: S2 drain and S2 load in the same cycle is legal; S2 loads the new op. S1 drain and S1 load in the same cycle is likewise legal.
- Illegal op on S1→S2:
  - out_result = 0, out_flags = 0, out_illegal = 1.
  - status_nzcv is not updated, regardless of set_flags.
- NZCV update (legal op, set_flags = 1), on the S1→S2 edge only:
  - N = result MSB; Z = (result == 0).
  - Arithmetic ops 8, 9, 10: C and V are loaded from the ALU carry_out and overflow.
  - Logical and shift ops 0-5: C and V retain their previous value.
  - With set_flags = 0, status_nzcv is unchanged.
- out_flags always carries the raw ALU {negative, zero, carry_out, overflow} for legal ops, independent of set_flags.
- Reset: s1_valid = 0, s2_valid = 0, out_result = 0, out_flags = 0, out_illegal = 0, status_nzcv = 0, in_ready = 1 during and after reset. Reset mid-operation discards all in-flight ops without producing output.
- Data registers may be left unreset; the valid registers must be reset.

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [3:0] alu_op_t: OP_OR=0, OP_XOR=1, OP_AND=2, OP_ROR=3, OP_SHR=4, OP_SHL=5, OP_ADD=8, OP_SUB=9, OP_ASR=10.
  - function is_legal_op.
  - function is_arith_op (8, 9, 10).
  - flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: nzcv_status_reg, holding the status register and its conditional C/V retention logic.
- arithmetic_logic_unit is instantiated unchanged.

Test Plan:
- Reset, then in_op=0, a=0x4C, b=0x65, out_ready=1 → out_valid rises in the second cycle after acceptance; out_result=0x6D; out_illegal=0.
- ADD a=0xCC, b=0xE5, set_flags=1 → out_result=0xB1; status_nzcv N=1, Z=0, C=1, V=0. Then OR a=0x00, b=0x00, set_flags=1 → result 0x00; status N=0, Z=1, C=1 (retained), V=0.
- Flag gating: SUB a=0xCC, b=0xCC with set_flags=0 → out_result=0x00 and out_flags Z=1, status_nzcv unchanged. ASR a=0xCC, b=0x03 → out_result=0xF9.
- Backpressure: hold out_ready=0 while in_valid=1 with 3 back-to-back ops (ROR 0x4C by 3, SHR 0x4C by 3, SHL 0x4C by 3):
  - in_ready drops after 2 ops are accepted.
  - The out_* ports stay stable while stalled.
  - Raising out_ready yields 0x89, 0x09, 0x60 in order, with no gaps once streaming.
- Illegal op 6 with set_flags=1 → out_illegal=1, out_result=0x00, out_flags=0, status_nzcv unchanged. The next legal op gives out_illegal=0.
- Accept 2 ops with out_ready=0, then assert rst for 1 cycle → out_valid=0, status_nzcv=0, in_ready=1. Neither discarded op ever appears on the output.
